hamming12_8_decoder: RTL
========================

# hamming12_8_decoder

Streaming Hamming(12,8) single-error-correcting decoder for the transceiver receive path. It accepts 12-bit codewords from the line side, computes the syndrome, corrects any single-bit error, flags uncorrectable syndromes, and delivers 8-bit data downstream through a two-stage valid/ready pipeline. Saturating error counters are kept for link-quality monitoring. It is the receive-side counterpart of the transmit-side 12/8 encoder and uses the same bit layout.

## Interface
- CNT_W, 16, width of each saturating error counter
- clk  in  1  system clock
- rst_n  in  1  one clock; reset is synchronous and active-low
- s_valid  in  1  input codeword valid
- s_ready  out  1  decoder can accept a codeword
- s_code  in  12  codeword; bit i = Hamming position i+1
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts the beat
- m_data  out  8  decoded or corrected data
- m_corr  out  1  a single-bit error was corrected in this beat
- m_uncorr  out  1  syndrome 13..15; data passed uncorrected
- m_syndrome  out  4  raw syndrome of this beat
- cnt_clr  in  1  synchronous clear of both counters
- cnt_corr  out  CNT_W  accepted beats with m_corr set, saturating
- cnt_uncorr  out  CNT_W  accepted beats with m_uncorr set, saturating

## Operation
- Layout: parity bits at positions 1, 2, 4, 8. Data bits d0..d7 at positions 3, 5, 6, 7, 9, 10, 11, 12.
- Syndrome bit k = XOR of all positions whose index has bit k set, for k = 0..3.
- Syndrome 0: no error. m_data = raw data bits, m_corr = 0, m_uncorr = 0.
- Syndrome 1..12: invert position s and extract data, m_corr = 1. If the flipped bit is a parity position, m_data equals the raw data but m_corr is still 1.
- Syndrome 13..15: no flip, m_data = raw data bits, m_uncorr = 1.
- Double errors that alias to syndromes 1..12 are miscorrected. This is accepted behaviour and is not detected.
- Stage 1 registers the codeword and its syndrome. Stage 2 registers the corrected data, flags and syndrome.
- Each stage loads when its own valid is low or the next stage can accept.
- s_ready = !v1 | !v2 | m_ready, combinational.
- Counters update only on output handshake (m_valid & m_ready) and saturate at all-ones.
- cnt_clr has priority over a same-cycle increment: that increment is lost.

## Timing
- Reset, synchronous while rst_n = 0:
  - v1, v2, m_valid = 0; m_data, m_syndrome = 0; m_corr, m_uncorr = 0; both counters = 0.
  - s_ready = 0 while rst_n is low.
- Latency: a codeword accepted at edge N is presented at edge N+2 with m_valid = 1, provided there is no stall.
- Throughput is 1 beat per cycle with m_ready held high. No bubbles are inserted.
- Backpressure:
  - m_valid and all m_* outputs are held stable while m_valid & !m_ready.
  - With both stages full and m_ready = 0, s_ready = 0 and no input is lost.
- Simultaneous load and drain in a stage in the same cycle is legal: the stage stays full with new contents.
- Reset asserted mid-stream discards both stages. In-flight beats are never emitted.
- Counters are visible on the cycle after the handshake edge.

## Structure
- Package hamming12_8_pkg holds:
  - CODE_W = 12, DATA_W = 8.
  - The data-position map constant.
  - Syndrome and correct/extract functions, shared with the encoder.
- Sub-module hamming12_8_syndrome: purely combinational, 12-bit codeword in, 4-bit syndrome out. Instantiated in stage 1.
- Everything else (pipeline registers, correction, counters) lives in the top module.

## Test plan
- Clean word: s_code = 0xA27 -> after 2 cycles m_data = 0xA5, m_syndrome = 0, m_corr = 0, m_uncorr = 0; counters unchanged.
- Single error in data: s_code = 0xA07 (position 6 flipped) -> m_data = 0xA5, m_syndrome = 6, m_corr = 1; cnt_corr increments by 1.
- Single error in parity: s_code = 0xA26 (position 1 flipped) -> m_data = 0xA5, m_syndrome = 1, m_corr = 1.
- Uncorrectable: s_code = 0xAB7 (positions 5 and 8 flipped) -> m_syndrome = 13, m_uncorr = 1, m_data = 0xA7; cnt_uncorr increments by 1.
- Backpressure: stream 0x000, 0xA27, 0xA07 with m_ready low for 3 cycles -> s_ready drops after 2 beats, outputs held stable, then 0x00, 0xA5, 0xA5 delivered in order with none lost or duplicated.
- Sweep and counter limits:
  - All 256 data values, each with random single flips at positions 1..12, must all decode to the original data.
  - With CNT_W = 2: 5 corrected beats -> cnt_corr = 3.
  - cnt_clr asserted together with a corrected handshake -> cnt_corr = 0.

Source files
------------

// File: rtl/hamming12_8_pkg.sv
// Shared definitions for the Hamming(12,8) codec: bit layout, syndrome masks
// and the syndrome / correct / extract helpers used by encoder and decoder.
package hamming12_8_pkg;

    localparam int CODE_W = 12;
    localparam int DATA_W = 8;
    localparam int SYN_W  = 4;

    // Hamming position (1-based) of each data bit d0..d7.
    localparam logic [DATA_W-1:0][3:0] DATA_POS = {
        4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
    };

    // Syndrome bit k covers every position whose 1-based index has bit k set.
    // Bit i of a mask corresponds to position i+1.
    localparam logic [SYN_W-1:0][CODE_W-1:0] SYN_MASK = {
        12'hF80,    // positions 8..12
        12'h878,    // positions 4..7, 12
        12'h666,    // positions 2, 3, 6, 7, 10, 11
        12'h555     // positions 1, 3, 5, 7, 9, 11
    };

    function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CODE_W-1:0] code);
        logic [SYN_W-1:0] syn;
        syn = '0;
        for (int k = 0; k < SYN_W; k++) begin
            syn[k] = ^(code & SYN_MASK[k]);
        end
        return syn;
    endfunction

    // Syndromes 1..12 point at a real position; 13..15 do not.
    function automatic logic syndrome_correctable(input logic [SYN_W-1:0] syn);
        return (syn >= 4'd1) && (syn <= 4'd12);
    endfunction

    function automatic logic [CODE_W-1:0] hamming_correct(input logic [CODE_W-1:0] code,
                                                          input logic [SYN_W-1:0]  syn);
        logic [CODE_W-1:0] fixed;
        fixed = code;
        if (syndrome_correctable(syn)) begin
            fixed[syn - 4'd1] = ~code[syn - 4'd1];
        end
        return fixed;
    endfunction

    function automatic logic [DATA_W-1:0] hamming_extract(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] data;
        data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data[i] = code[DATA_POS[i] - 4'd1];
        end
        return data;
    endfunction

endpackage

// File: rtl/hamming12_8_syndrome.sv
// Combinational syndrome generator: one parity tree per syndrome bit.
module hamming12_8_syndrome
    import hamming12_8_pkg::*;
(
    input  logic [11:0] code,
    output logic [3:0]  syndrome
);

    genvar gi;
    generate
        for (gi = 0; gi < SYN_W; gi++) begin : g_syn
            assign syndrome[gi] = ^(code & SYN_MASK[gi]);
        end
    endgenerate

endmodule

// File: rtl/hamming12_8_decoder.sv
// Streaming Hamming(12,8) SEC decoder. Stage 1 holds the codeword and its
// syndrome, stage 2 holds corrected data and flags. Saturating counters track
// corrected and uncorrectable beats as they leave the block.
module hamming12_8_decoder
    import hamming12_8_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [11:0]      s_code,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_corr,
    output logic             m_uncorr,
    output logic [3:0]       m_syndrome,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_uncorr
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              v1_reg;
    logic [11:0]       code1_reg;
    logic [3:0]        syn1_reg;
    logic              v2_reg;
    logic [7:0]        data2_reg;
    logic              corr2_reg;
    logic              uncorr2_reg;
    logic [3:0]        syn2_reg;
    logic [CNT_W-1:0]  cnt_corr_reg;
    logic [CNT_W-1:0]  cnt_uncorr_reg;

    logic [3:0]        syn_next;
    logic [11:0]       fixed_code;
    logic [7:0]        data_next;
    logic              corr_next;
    logic              uncorr_next;
    logic              ld1;
    logic              ld2;
    logic              out_hs;

    hamming12_8_syndrome u_syndrome (
        .code     (s_code),
        .syndrome (syn_next)
    );

    // A stage may load when it is empty or the stage after it can take its beat.
    assign ld2     = !v2_reg || m_ready;
    assign ld1     = !v1_reg || ld2;
    assign s_ready = rst_n && ld1;
    assign out_hs  = v2_reg && m_ready;

    assign fixed_code  = hamming_correct(code1_reg, syn1_reg);
    assign data_next   = hamming_extract(fixed_code);
    assign corr_next   = syndrome_correctable(syn1_reg);
    assign uncorr_next = (syn1_reg != 4'd0) && !corr_next;

    // Stage 1: capture the incoming codeword together with its syndrome.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_reg    <= 1'b0;
            code1_reg <= '0;
            syn1_reg  <= '0;
        end else if (ld1) begin
            v1_reg <= s_valid;
            if (s_valid) begin
                code1_reg <= s_code;
                syn1_reg  <= syn_next;
            end
        end
    end

    // Stage 2: register corrected data and flags; held while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_reg      <= 1'b0;
            data2_reg   <= '0;
            corr2_reg   <= 1'b0;
            uncorr2_reg <= 1'b0;
            syn2_reg    <= '0;
        end else if (ld2) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                data2_reg   <= data_next;
                corr2_reg   <= corr_next;
                uncorr2_reg <= uncorr_next;
                syn2_reg    <= syn1_reg;
            end
        end
    end

    // Error counters advance on output handshakes only; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            cnt_corr_reg   <= '0;
            cnt_uncorr_reg <= '0;
        end else begin
            if (out_hs && corr2_reg && (cnt_corr_reg != CNT_MAX)) begin
                cnt_corr_reg <= cnt_corr_reg + CNT_ONE;
            end
            if (out_hs && uncorr2_reg && (cnt_uncorr_reg != CNT_MAX)) begin
                cnt_uncorr_reg <= cnt_uncorr_reg + CNT_ONE;
            end
        end
    end

    assign m_valid    = v2_reg;
    assign m_data     = data2_reg;
    assign m_corr     = corr2_reg;
    assign m_uncorr   = uncorr2_reg;
    assign m_syndrome = syn2_reg;
    assign cnt_corr   = cnt_corr_reg;
    assign cnt_uncorr = cnt_uncorr_reg;

endmodule
